sreg_piso_tx: RTL and testbench
===============================

Name: sreg_piso_tx

Overview:
Parallel-in/serial-out transmitter that feeds the sreg_sipo deserializer. It accepts WIDTH-bit words over a valid/ready handshake and stores them in a one-word holding buffer. Each word is shifted out one bit per clock on sout. After the last bit it emits a one-cycle rd strobe, which tells the downstream sreg_sipo that its parallel word is complete. Back-to-back frames run without bubbles when GAP=0.

Parameters:
WIDTH, 8, bits per frame (>=2)
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first
GAP, 0, idle cycles inserted after each frame before the next frame may load (0..15)

Ports:
sys_clk  input  1  single clock; all logic on rising edge
sys_rst_n  input  1  reset, asynchronous, active-low
din  input  WIDTH  parallel word to send
din_valid  input  1  din is valid
din_ready  output  1  holding buffer can accept; transfer occurs when din_valid && din_ready at a rising edge
sout  output  1  serial data to sreg_sipo.sin
rd  output  1  one-cycle strobe: frame complete, connects to sreg_sipo.rd
busy  output  1  high when state != IDLE or the buffer is full

Behaviour:
- Reset (async, sys_rst_n=0):
  - state=IDLE; buffer empty; shift register, bit counter and gap counter cleared.
  - Outputs: sout=0, rd=0, busy=0, din_ready=1 (once reset deasserts).
- din_ready = !buf_full, driven directly from flops. din_valid is ignored while din_ready=0; din must stay stable until accepted.
- State IDLE:
  - sout=0.
  - If buf_full at an edge: load the shift register from the buffer, cnt=0, go to SHIFT, clear buf_full.
  - If an accept happens on that same edge, buf_full stays 1 and the buffer holds the new word.
- State SHIFT:
  - sout = shift-register MSB if MSB_FIRST, else LSB.
  - At each edge: shift by one and cnt++. At the edge where cnt==WIDTH-1, the frame ends.
- Frame end:
  - rd=1 for exactly the next cycle.
  - If GAP==0 and buf_full: load the next word on that same edge, stay in SHIFT, so bits are contiguous.
  - Else if GAP>0: go to GAP with gcnt=0. After GAP cycles, go to IDLE.
  - Else: go to IDLE.
- State GAP: sout=0. Accepts into the buffer are still allowed.
- Latency, with buffer empty and state IDLE:
  - Accept at edge E0 → load at E1 → bit k on sout during cycle (E1+k, E1+k+1), k=0..WIDTH-1.
  - rd high during cycle (E1+WIDTH, E1+WIDTH+1).
- Simultaneous accept and drain on the same edge: the new word lands in the buffer. No data loss, no duplication.
- Reset mid-frame: the frame is aborted, the buffer is discarded, and no rd pulse is issued.
- Counter widths: cnt is $clog2(WIDTH) bits; gcnt is 4 bits. No wrap beyond the terminal counts.

Decomposition:
- Shared package holds the state encoding typedef (IDLE, SHIFT, GAP) and the default WIDTH constant shared with sreg_sipo.
- Optional sub-module piso_hold_buf: one-word buffer with valid/ready and a drain input, reusable on the transmit side.
- FSM, counters and shifter stay in sreg_piso_tx.

Test Plan:
- Single word, MSB_FIRST=1, GAP=0: accept 8'hA5 at E0 → sout = 1,0,1,0,0,1,0,1 over cycles E1..E8 → rd high one cycle at E9 → busy falls after E9.
- Back-to-back, GAP=0:
  - Stimulus: 8'hA5 accepted, then 8'h3C accepted while the first frame is shifting.
  - Required: 16 contiguous bits 10100101 00111100, rd pulses at E9 and E17, sout never idles between frames.
- Backpressure: hold din_valid=1 with three words queued → din_ready=0 while the buffer is full → exactly three frames emitted in order, none dropped.
- LSB_FIRST (MSB_FIRST=0): send 8'h01 → first sout bit 1, then seven 0s → rd one pulse.
- GAP=2: two words back-to-back → exactly 2 cycles with sout=0 between the last bit of frame 1 and the first bit of frame 2 → 2 rd pulses.
- Reset mid-frame: assert sys_rst_n=0 after 4 bits of 8'hFF → sout=0, busy=0, din_ready=1 immediately (async) → no rd pulse → next word 8'h81 transmits correctly after release.
- Loopback: connect to sreg_sipo and send 8'hC3 → sreg_sipo.sout == 8'hC3 while rd is high.

Source files
------------

// File: rtl/sreg_piso_tx_pkg.sv
// Shared definitions for the sreg serial link: the transmitter state encoding
// and the default frame width agreed with the sreg_sipo receiver.
package sreg_piso_tx_pkg;

  localparam int SREG_WIDTH = 8;
  localparam int GAP_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_t;

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer with a valid/ready write port and a drain strobe.
// Ready is kept in its own flop so the upstream handshake sees a clean register.
module piso_hold_buf
  import sreg_piso_tx_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic accept;

  assign accept = wr_valid && wr_ready;

  // A write on the same edge as a drain wins: the new word replaces the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      wr_ready <= 1'b1;
      data     <= '0;
    end else begin
      if (accept) begin
        data     <= wr_data;
        full     <= 1'b1;
        wr_ready <= 1'b0;
      end else if (drain) begin
        full     <= 1'b0;
        wr_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sreg_piso_tx.sv
// Parallel-in/serial-out transmitter feeding sreg_sipo: one bit per clock on
// sout, followed by a one-cycle rd strobe after the last bit of every frame.
module sreg_piso_tx
  import sreg_piso_tx_pkg::*;
#(
  parameter int WIDTH     = SREG_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             rd,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GCNT_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  piso_state_t          state;
  logic [WIDTH-1:0]     shreg;
  logic [CNT_W-1:0]     cnt;
  logic [GAP_CNT_W-1:0] gcnt;
  logic                 buf_full;
  logic [WIDTH-1:0]     buf_data;
  logic                 frame_end;
  logic                 gap_end;
  logic                 load;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .wr_data  (din),
    .wr_valid (din_valid),
    .wr_ready (din_ready),
    .drain    (load),
    .full     (buf_full),
    .data     (buf_data)
  );

  assign frame_end = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign gap_end   = (state == ST_GAP) && (gcnt == GCNT_LAST);

  // The last gap cycle loads a waiting word directly, so exactly GAP idle
  // cycles separate back-to-back frames.
  assign load = buf_full && ((state == ST_IDLE) || (frame_end && (GAP == 0)) || gap_end);

  assign busy = (state != ST_IDLE) || buf_full;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      sout  <= 1'b0;
      rd    <= 1'b0;
    end else begin
      rd <= frame_end;
      if (load) begin
        state <= ST_SHIFT;
        shreg <= buf_data;
        cnt   <= '0;
        sout  <= head_bit(buf_data);
      end else begin
        case (state)
          ST_IDLE: begin
            sout <= 1'b0;
          end
          ST_SHIFT: begin
            if (frame_end) begin
              sout <= 1'b0;
              cnt  <= '0;
              if (GAP > 0) begin
                state <= ST_GAP;
                gcnt  <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              shreg <= shift_word(shreg);
              sout  <= head_bit(shift_word(shreg));
              cnt   <= cnt + 1'b1;
            end
          end
          ST_GAP: begin
            sout <= 1'b0;
            if (gap_end) begin
              state <= ST_IDLE;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            sout  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sreg_piso_tx.sv
// Bench for sreg_piso_tx: three instances (MSB/GAP0, LSB/GAP0, MSB/GAP2) checked
// every cycle against a frame-timeline model, plus directed literal checks.
module tb_sreg_piso_tx;

  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din = '0;
  logic [N-1:0] valid = '0;
  logic [N-1:0] ready, sout, rd, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_valid(valid[0]),
    .din_ready(ready[0]), .sout(sout[0]), .rd(rd[0]), .busy(busy[0]));
  sreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_valid(valid[1]),
    .din_ready(ready[1]), .sout(sout[1]), .rd(rd[1]), .busy(busy[1]));
  sreg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(2)) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .din(din), .din_valid(valid[2]),
    .din_ready(ready[2]), .sout(sout[2]), .rd(rd[2]), .busy(busy[2]));

  function automatic int gap_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  function automatic void chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_w(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Model: each frame is a (word, start cycle) pair; a word accepted at edge e
  // starts at max(e+1, previous start + W + GAP). Everything else follows.
  int           m_cyc = 0;
  bit           m_pend[N];
  logic [W-1:0] m_pword[N];
  int           m_pstart[N];
  bit           m_hl[N], m_hp[N];
  int           m_ls[N], m_ps[N];
  logic [W-1:0] m_lw[N];

  always @(posedge clk) begin
    m_cyc++;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_pend[i] = 1'b0;
        m_hl[i]   = 1'b0;
        m_hp[i]   = 1'b0;
      end else begin
        if (valid[i] && !m_pend[i]) begin
          m_pend[i]  = 1'b1;
          m_pword[i] = din;
          m_pstart[i] = m_cyc + 1;
          if (m_hl[i] && (m_ls[i] + W + gap_of(i) > m_pstart[i]))
            m_pstart[i] = m_ls[i] + W + gap_of(i);
        end
        if (m_pend[i] && m_pstart[i] == m_cyc) begin
          m_hp[i]   = m_hl[i];
          m_ps[i]   = m_ls[i];
          m_hl[i]   = 1'b1;
          m_ls[i]   = m_cyc;
          m_lw[i]   = m_pword[i];
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  function automatic logic exp_sout(input int i);
    int k;
    if (!m_hl[i]) return 1'b0;
    k = m_cyc - m_ls[i];
    if (k < 0 || k >= W) return 1'b0;
    return msb_of(i) ? m_lw[i][W-1-k] : m_lw[i][k];
  endfunction

  function automatic logic exp_rd(input int i);
    return (m_hl[i] && m_cyc == m_ls[i] + W) || (m_hp[i] && m_cyc == m_ps[i] + W);
  endfunction

  function automatic logic exp_busy(input int i);
    return m_pend[i] || (m_hl[i] && m_cyc < m_ls[i] + W + gap_of(i));
  endfunction

  // Receiver stand-in (sreg_sipo behaviour) and rd bookkeeping.
  logic [W-1:0] sipo[N];
  logic [W-1:0] lb0[$], lb1[$], lb2[$];
  int rd_cnt[N], rd_last[N], rd_gap[N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      sipo[i] <= msb_of(i) ? {sipo[i][W-2:0], sout[i]} : {sout[i], sipo[i][W-1:1]};
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_sout%0d", i), sout[i], 1'b0);
        chk($sformatf("rst_rd%0d", i), rd[i], 1'b0);
        chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
        chk($sformatf("rst_ready%0d", i), ready[i], 1'b1);
      end else begin
        chk($sformatf("sout%0d@%0d", i, m_cyc), sout[i], exp_sout(i));
        chk($sformatf("rd%0d@%0d", i, m_cyc), rd[i], exp_rd(i));
        chk($sformatf("busy%0d@%0d", i, m_cyc), busy[i], exp_busy(i));
        chk($sformatf("ready%0d@%0d", i, m_cyc), ready[i], !m_pend[i]);
        if (rd[i] === 1'b1) begin
          rd_cnt[i]++;
          rd_gap[i]  = m_cyc - rd_last[i];
          rd_last[i] = m_cyc;
          if (i == 0) lb0.push_back(sipo[i]);
          else if (i == 1) lb1.push_back(sipo[i]);
          else lb2.push_back(sipo[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds din/valid until the instance accepts.
  task automatic send(input int i, input logic [W-1:0] w);
    bit rdy = 1'b0;
    bit ok = 1'b0;
    din = w;
    valid[i] = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      rdy = ready[i];
      tick();
      ok = rdy;
    end
    valid[i] = 1'b0;
    if (!ok) chk_w($sformatf("accept_timeout%0d", i), 0, 1);
  endtask

  task automatic wait_idle(input int i);
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      tick();
      done = !busy[i] && ready[i];
    end
    if (!done) chk_w($sformatf("idle_timeout%0d", i), 0, 1);
    tick();
    tick();
  endtask

  task automatic expect_lb(input int i, input logic [W-1:0] w);
    logic [W-1:0] got;
    int sz;
    sz = (i == 0) ? lb0.size() : (i == 1) ? lb1.size() : lb2.size();
    if (sz == 0) begin
      chk_w($sformatf("loopback%0d_empty", i), 0, int'(w));
    end else begin
      got = (i == 0) ? lb0.pop_front() : (i == 1) ? lb1.pop_front() : lb2.pop_front();
      chk_w($sformatf("loopback%0d_word", i), int'(got), int'(w));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cap;
    int base;

    #2 rst_n = 1'b0;
    #1;
    chk("init_ready", ready[0], 1'b1);
    chk("init_busy", busy[0], 1'b0);
    chk("init_sout", sout[0], 1'b0);
    chk("init_rd", rd[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word, MSB first: A5 -> 1,0,1,0,0,1,0,1 then rd.
    send(0, 8'hA5);
    for (int k = 0; k < W; k++) begin
      tick();
      cap[W-1-k] = sout[0];
    end
    chk_w("single_bits", int'(cap), 32'hA5);
    tick();
    chk("single_rd", rd[0], 1'b1);
    chk("single_busy", busy[0], 1'b0);
    tick();
    chk("single_rd_end", rd[0], 1'b0);
    wait_idle(0);
    expect_lb(0, 8'hA5);

    // LSB first: 01 -> 1 then seven 0s.
    base = rd_cnt[1];
    send(1, 8'h01);
    for (int k = 0; k < W; k++) begin
      tick();
      cap[W-1-k] = sout[1];
    end
    chk_w("lsb_bits", int'(cap), 32'h80);
    tick();
    chk("lsb_rd", rd[1], 1'b1);
    wait_idle(1);
    chk_w("lsb_rd_count", rd_cnt[1] - base, 1);
    expect_lb(1, 8'h01);

    // Back-to-back with GAP=0: rd pulses exactly W cycles apart.
    base = rd_cnt[0];
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_idle(0);
    chk_w("b2b_rd_count", rd_cnt[0] - base, 2);
    chk_w("b2b_rd_spacing", rd_gap[0], W);
    expect_lb(0, 8'hA5);
    expect_lb(0, 8'h3C);

    // Backpressure: three words queued with valid held.
    base = rd_cnt[0];
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    wait_idle(0);
    chk_w("bp_rd_count", rd_cnt[0] - base, 3);
    expect_lb(0, 8'h11);
    expect_lb(0, 8'h22);
    expect_lb(0, 8'h33);

    // GAP=2: two idle cycles between frames, rd pulses W+2 apart.
    base = rd_cnt[2];
    send(2, 8'hA5);
    send(2, 8'h3C);
    wait_idle(2);
    chk_w("gap_rd_count", rd_cnt[2] - base, 2);
    chk_w("gap_rd_spacing", rd_gap[2], W + 2);
    expect_lb(2, 8'hA5);
    expect_lb(2, 8'h3C);

    // Reset mid-frame: async clear, no rd for the aborted frame.
    base = rd_cnt[0];
    send(0, 8'hFF);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sout", sout[0], 1'b0);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_ready", ready[0], 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) tick();
    chk_w("midrst_no_rd", rd_cnt[0] - base, 0);
    lb0.delete();
    send(0, 8'h81);
    wait_idle(0);
    chk_w("post_rst_rd_count", rd_cnt[0] - base, 1);
    expect_lb(0, 8'h81);

    // Loopback into the receiver stand-in.
    send(0, 8'hC3);
    wait_idle(0);
    expect_lb(0, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
